// File: rtl/rfphoenix_issue_arbiter_pkg.sv
// Shared types for the rfPhoenix issue/fetch scheduler.
package rfphoenix_issue_arbiter_pkg;

   localparam int unsigned NTHREADS_DEF = 4;
   localparam int unsigned TW_DEF       = $clog2(NTHREADS_DEF);

   typedef logic [TW_DEF-1:0] tid_t;

   typedef enum logic [1:0] {
      OFF    = 2'd0,
      RUN    = 2'd1,
      BRWAIT = 2'd2,
      FLUSH  = 2'd3
   } thread_state_t;

   // A thread may be fetched for while running or while waiting on a branch.
   function automatic logic fetchable(input thread_state_t s);
      return (s == RUN) || (s == BRWAIT);
   endfunction

endpackage

// File: rtl/rfphoenix_issue_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past ptr and wraps.
module rfphoenix_rr_arbiter #(
   parameter int unsigned N  = 4,
   parameter int unsigned TW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [TW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [TW-1:0] tid,
   output logic          any
);

   logic [TW-1:0] idx;

   // First requester found walking ptr+1, ptr+2, ... ptr (mod N).
   always_comb begin
      grant = '0;
      tid   = '0;
      any   = 1'b0;
      idx   = '0;
      for (int unsigned i = 1; i <= N; i++) begin
         idx = ptr + TW'(i);
         if (!any && req[idx]) begin
            any        = 1'b1;
            grant[idx] = 1'b1;
            tid        = idx;
         end
      end
   end

endmodule

// File: rtl/rfphoenix_issue_arbiter.sv
// Per-thread issue and fetch scheduler for the rfPhoenix pipeline.
module rfphoenix_issue_arbiter
   import rfphoenix_issue_arbiter_pkg::*;
#(
   parameter int unsigned NTHREADS = NTHREADS_DEF,
   parameter int unsigned TW       = $clog2(NTHREADS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NTHREADS-1:0] thread_en,
   input  logic [NTHREADS-1:0] fifo_v,
   input  logic [NTHREADS-1:0] fifo_af,
   input  logic [NTHREADS-1:0] fifo_is_br,
   input  logic [NTHREADS-1:0] thread_stall,
   input  logic                issue_rdy,
   input  logic                br_done,
   input  logic [TW-1:0]       br_tid,
   input  logic                br_miss,
   input  logic                fetch_ack,
   output logic [NTHREADS-1:0] fifo_rd,
   output logic [NTHREADS-1:0] fifo_flush,
   output logic                issue_v,
   output logic [TW-1:0]       issue_tid,
   output logic                fetch_v,
   output logic [TW-1:0]       fetch_tid
);

   thread_state_t       state [NTHREADS];
   logic [TW-1:0]       issue_ptr;
   logic [TW-1:0]       fetch_ptr;

   logic [NTHREADS-1:0] br_hit;
   logic [NTHREADS-1:0] leave;
   logic [NTHREADS-1:0] issue_req;
   logic [NTHREADS-1:0] fetch_req;

   logic [NTHREADS-1:0] issue_grant;
   logic [TW-1:0]       issue_gtid;
   logic                issue_any;
   logic [NTHREADS-1:0] fetch_grant;
   logic [TW-1:0]       fetch_gtid;
   logic                fetch_any;

   // Eligibility vectors and per-thread branch-resolution decode.
   // leave[t] flags a thread dropping out of RUN/BRWAIT at the coming edge;
   // fetch requests are masked with it so a thread is never handed to the
   // fetch unit in the cycle it enters FLUSH or OFF.
   always_comb begin
      br_hit    = '0;
      leave     = '0;
      issue_req = '0;
      fetch_req = '0;
      for (int unsigned t = 0; t < NTHREADS; t++) begin
         br_hit[t]    = br_done && (br_tid == TW'(t));
         leave[t]     = fetchable(state[t]) &&
                        (!thread_en[t] ||
                         ((state[t] == BRWAIT) && br_hit[t] && br_miss));
         issue_req[t] = (state[t] == RUN) && fifo_v[t] &&
                        !thread_stall[t] && issue_rdy;
         fetch_req[t] = fetchable(state[t]) && !leave[t] && !fifo_af[t];
      end
   end

   rfphoenix_rr_arbiter #(
      .N  (NTHREADS),
      .TW (TW)
   ) u_issue_arb (
      .req   (issue_req),
      .ptr   (issue_ptr),
      .grant (issue_grant),
      .tid   (issue_gtid),
      .any   (issue_any)
   );

   rfphoenix_rr_arbiter #(
      .N  (NTHREADS),
      .TW (TW)
   ) u_fetch_arb (
      .req   (fetch_req),
      .ptr   (fetch_ptr),
      .grant (fetch_grant),
      .tid   (fetch_gtid),
      .any   (fetch_any)
   );

   // Pop is combinational so the FIFO data registers alongside issue_v.
   always_comb begin
      fifo_rd = issue_grant;
   end

   // Per-thread state machines and FIFO flush pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned t = 0; t < NTHREADS; t++) begin
            state[t] <= OFF;
         end
         fifo_flush <= '0;
      end else begin
         fifo_flush <= '0;
         for (int unsigned t = 0; t < NTHREADS; t++) begin
            if (!thread_en[t]) begin
               state[t]      <= OFF;
               fifo_flush[t] <= (state[t] != OFF);
            end else begin
               case (state[t])
                  OFF:     state[t] <= RUN;
                  RUN:     if (issue_grant[t] && fifo_is_br[t]) state[t] <= BRWAIT;
                  BRWAIT:  if (br_hit[t]) begin
                              if (br_miss) begin
                                 state[t]      <= FLUSH;
                                 fifo_flush[t] <= 1'b1;
                              end else begin
                                 state[t] <= RUN;
                              end
                           end
                  FLUSH:   state[t] <= RUN;
                  default: state[t] <= OFF;
               endcase
            end
         end
      end
   end

   // Issue output registers and issue round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         issue_v   <= 1'b0;
         issue_tid <= '0;
         issue_ptr <= TW'(NTHREADS - 1);
      end else begin
         issue_v <= issue_any;
         if (issue_any) begin
            issue_tid <= issue_gtid;
            issue_ptr <= issue_gtid;
         end
      end
   end

   // Fetch request handshake and fetch round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_v   <= 1'b0;
         fetch_tid <= '0;
         fetch_ptr <= TW'(NTHREADS - 1);
      end else if (fetch_v && !fetch_ack) begin
         if (leave[fetch_tid]) begin
            fetch_v <= 1'b0;
         end
      end else begin
         fetch_v <= fetch_any;
         if (fetch_any) begin
            fetch_tid <= fetch_gtid;
            fetch_ptr <= fetch_gtid;
         end
      end
   end

endmodule

// File: tb/tb_rfphoenix_issue_arbiter.sv
// Directed test of rfphoenix_issue_arbiter with hand-computed expectations.
module tb_rfphoenix_issue_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] thread_en;
   logic [3:0] fifo_v;
   logic [3:0] fifo_af;
   logic [3:0] fifo_is_br;
   logic [3:0] thread_stall;
   logic       issue_rdy;
   logic       br_done;
   logic [1:0] br_tid;
   logic       br_miss;
   logic       fetch_ack;
   logic [3:0] fifo_rd;
   logic [3:0] fifo_flush;
   logic       issue_v;
   logic [1:0] issue_tid;
   logic       fetch_v;
   logic [1:0] fetch_tid;

   int n_vec  = 0;
   int n_miss = 0;

   rfphoenix_issue_arbiter #(
      .NTHREADS (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .thread_en    (thread_en),
      .fifo_v       (fifo_v),
      .fifo_af      (fifo_af),
      .fifo_is_br   (fifo_is_br),
      .thread_stall (thread_stall),
      .issue_rdy    (issue_rdy),
      .br_done      (br_done),
      .br_tid       (br_tid),
      .br_miss      (br_miss),
      .fetch_ack    (fetch_ack),
      .fifo_rd      (fifo_rd),
      .fifo_flush   (fifo_flush),
      .issue_v      (issue_v),
      .issue_tid    (issue_tid),
      .fetch_v      (fetch_v),
      .fetch_tid    (fetch_tid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; thread_en = '0; fifo_v = '0; fifo_af = '0; fifo_is_br = '0;
      thread_stall = '0; issue_rdy = 1'b0; br_done = 1'b0; br_tid = '0;
      br_miss = 1'b0; fetch_ack = 1'b0;
      tick(); tick();
      check("rst_rd", 32'(fifo_rd), 0);
      check("rst_flush", 32'(fifo_flush), 0);
      check("rst_iv", 32'(issue_v), 0);
      check("rst_itid", 32'(issue_tid), 0);
      check("rst_fv", 32'(fetch_v), 0);
      check("rst_ftid", 32'(fetch_tid), 0);

      // Round-robin issue over four busy threads.
      rst = 1'b0; thread_en = 4'hF; fifo_v = 4'hF; issue_rdy = 1'b1; fetch_ack = 1'b1;
      #1;
      check("off_rd", 32'(fifo_rd), 0);
      tick();
      for (int k = 0; k < 5; k++) begin
         check("rr_rd", 32'(fifo_rd), 32'(1) << (k % 4));
         check("rr_iv", 32'(issue_v), 32'(k > 0));
         if (k > 0) check("rr_itid", 32'(issue_tid), 32'((k - 1) % 4));
         tick();
      end

      // Thread 1 blocks behind a branch, resolved without a miss.
      fifo_is_br = 4'b0010; #1;
      check("br_rd1", 32'(fifo_rd), 32'b0010);
      tick();
      fifo_is_br = '0; #1;
      check("br_itid1", 32'(issue_tid), 1);
      check("br_rd2", 32'(fifo_rd), 32'b0100);
      tick();
      check("br_rd3", 32'(fifo_rd), 32'b1000);
      tick();
      check("br_rd0", 32'(fifo_rd), 32'b0001);
      tick();
      br_done = 1'b1; br_tid = 2'd1; br_miss = 1'b0; #1;
      check("br_skip1", 32'(fifo_rd), 32'b0100);
      tick();
      br_done = 1'b0; #1;
      check("br_res3", 32'(fifo_rd), 32'b1000);
      tick();
      check("br_res0", 32'(fifo_rd), 32'b0001);
      tick();
      check("br_back1", 32'(fifo_rd), 32'b0010);
      tick();

      // Thread 2 mispredicts: one-cycle flush, then back in RUN.
      fifo_is_br = 4'b0100; #1;
      check("mp_rd2", 32'(fifo_rd), 32'b0100);
      tick();
      fifo_is_br = '0; br_done = 1'b1; br_tid = 2'd2; br_miss = 1'b1; #1;
      check("mp_rd3", 32'(fifo_rd), 32'b1000);
      check("mp_noflush", 32'(fifo_flush), 0);
      tick();
      br_done = 1'b0; br_miss = 1'b0; #1;
      check("mp_flush", 32'(fifo_flush), 32'b0100);
      check("mp_rd0", 32'(fifo_rd), 32'b0001);
      check("mp_nofetch_a", 32'(fetch_v && fetch_tid == 2'd2), 0);
      tick();
      check("mp_flush_end", 32'(fifo_flush), 0);
      check("mp_rd1", 32'(fifo_rd), 32'b0010);
      check("mp_nofetch_b", 32'(fetch_v && fetch_tid == 2'd2), 0);
      tick();
      check("mp_rd2_again", 32'(fifo_rd), 32'b0100);
      tick();

      // Fresh reset: fetch rotation with thread 0 almost full.
      rst = 1'b1; issue_rdy = 1'b0; fifo_af = 4'b0001;
      tick(); tick();
      rst = 1'b0;
      tick();
      check("f_v0", 32'(fetch_v), 0);
      check("nr_rd", 32'(fifo_rd), 0);
      tick();
      check("f_v1", 32'(fetch_v), 1);
      check("f_t1", 32'(fetch_tid), 1);
      check("nr_iv", 32'(issue_v), 0);
      tick();
      check("f_t2", 32'(fetch_tid), 2);
      tick();
      check("f_t3", 32'(fetch_tid), 3);
      tick();
      check("f_t1b", 32'(fetch_tid), 1);
      fetch_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("f_hold_v", 32'(fetch_v), 1);
         check("f_hold_t", 32'(fetch_tid), 1);
      end
      fetch_ack = 1'b1;
      tick();
      check("f_t2b", 32'(fetch_tid), 2);

      // Issue pointer unchanged while nothing was eligible; stall blocks issue.
      issue_rdy = 1'b1; #1;
      check("ip_rd0", 32'(fifo_rd), 32'b0001);
      tick();
      check("ip_iv", 32'(issue_v), 1);
      check("ip_itid", 32'(issue_tid), 0);
      thread_stall = 4'hF; #1;
      check("st_rd", 32'(fifo_rd), 0);
      tick();
      check("st_iv", 32'(issue_v), 0);
      thread_stall = '0; #1;
      check("st_rd1", 32'(fifo_rd), 32'b0010);
      tick();

      // Thread 3 disabled while in BRWAIT; a later br_done for it is ignored.
      fifo_is_br = 4'b1000; #1;
      check("off_rd2", 32'(fifo_rd), 32'b0100);
      tick();
      check("off_rd3", 32'(fifo_rd), 32'b1000);
      tick();
      fifo_is_br = '0; thread_en = 4'b0111; #1;
      check("off_rd0", 32'(fifo_rd), 32'b0001);
      tick();
      check("off_flush", 32'(fifo_flush), 32'b1000);
      check("off_rd1", 32'(fifo_rd), 32'b0010);
      check("off_nofetch", 32'(fetch_v && fetch_tid == 2'd3), 0);
      br_done = 1'b1; br_tid = 2'd3; br_miss = 1'b1;
      tick();
      br_done = 1'b0; br_miss = 1'b0; #1;
      check("off_noflush", 32'(fifo_flush), 0);
      check("off_rd2b", 32'(fifo_rd), 32'b0100);
      tick();
      check("off_skip3", 32'(fifo_rd), 32'b0001);
      check("off_noflush2", 32'(fifo_flush), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
